// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Uses a start/ready handshake with the EX stage; result_o = {remainder, quotient}.
module div_radix2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;

    logic             abort;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        abort   = flush | annul_i;
        abs_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        // quo holds the unconsumed dividend bits at the top and the quotient at the bottom
        shifted = {rem, quo[WIDTH-1]};
        if (shifted >= {1'b0, dvsr}) begin
            rem_n = WIDTH'(shifted - {1'b0, dvsr});
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = shifted[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
        q_fix = neg_q ? -quo_n : quo_n;
        r_fix = neg_r ? -rem_n : rem_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !abort) begin
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= abs_a;
                        dvsr  <= abs_b;
                        neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r <= signed_div_i & opdata1_i[WIDTH-1];
                        state <= (opdata2_i == '0) ? DIVZERO : BUSY;
                    end
                end
                DIVZERO: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state    <= DONE;
                        ready_o  <= 1'b1;
                        result_o <= '0;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_n;
                        quo <= quo_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state    <= DONE;
                            ready_o  <= 1'b1;
                            result_o <= {r_fix, q_fix};
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2: stimulus pushes expected {result, cycle},
// a negedge monitor pops and compares on every ready_o pulse.
module tb_div_radix2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic        signed_div = 1'b0;
    logic        ready_o;
    logic [63:0] result_o;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;
    logic [63:0] sb_res[$];
    int unsigned sb_cyc[$];
    logic [63:0] last_res = '0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .opdata1_i(opdata1), .opdata2_i(opdata2),
        .start_i(start), .annul_i(annul), .signed_div_i(signed_div),
        .ready_o(ready_o), .result_o(result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && ready_o) begin
            logic [63:0] er;
            int unsigned ec;
            checks++;
            if (sb_res.size() == 0) begin
                $display("FAIL unexpected_ready: cycle %0d result %h, no request pending", cyc, result_o);
            end else begin
                er = sb_res.pop_front();
                ec = sb_cyc.pop_front();
                if (result_o === er && cyc == ec) passed++;
                else $display("FAIL result: got %h at cycle %0d expected %h at cycle %0d",
                              result_o, cyc, er, ec);
            end
        end
    end

    // Holds start until ready_o, scrambling operands/sign after accept
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int unsigned acc;
        @(negedge clk);
        opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
        acc = cyc;
        last_res = model(a, b, s);
        sb_res.push_back(last_res);
        sb_cyc.push_back(acc + ((b == 0) ? 2 : 33));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready_o) begin
                start = 1'b0;
                return;
            end
            opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
        end
        start = 1'b0;
        chk("ready_timeout", 64'd0, 64'd1);
    endtask

    // kind: 0 = flush, 1 = annul, 2 = reset, applied in cycle 'at' after accept
    task automatic abort_div(input logic [31:0] a, input logic [31:0] b, input int unsigned at,
                             input int unsigned kind);
        int unsigned acc;
        @(negedge clk);
        opdata1 = a; opdata2 = b; signed_div = 1'b0; start = 1'b1;
        acc = cyc;
        while (cyc < acc + at) @(negedge clk);
        start = 1'b0;
        if (kind == 0) flush = 1'b1;
        else if (kind == 1) annul = 1'b1;
        else rst = 1'b1;
        @(negedge clk);
        flush = 1'b0; annul = 1'b0;
        if (kind == 2) begin
            rst = 1'b0;
            chk("rst_ready", {63'd0, ready_o}, 64'd0);
            chk("rst_result", result_o, 64'd0);
            last_res = '0;
        end
        repeat (40) @(negedge clk);
        chk("abort_no_ready", {63'd0, ready_o}, 64'd0);
        chk("abort_result_kept", result_o, last_res);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;

        do_div(32'd100, 32'd7, 1'b0);
        chk("divu_100_7", last_res, 64'h00000002_0000000E);
        do_div(32'hFFFFFFF9, 32'h2, 1'b1);
        do_div(32'd7, 32'hFFFFFFFE, 1'b1);
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b0);
        do_div(32'hFFFFFFFF, 32'd1, 1'b0);
        do_div(32'd1234, 32'd0, 1'b0);
        do_div(32'hFFFFFF00, 32'd0, 1'b1);
        do_div(32'd5, 32'd9, 1'b1);

        abort_div(32'd1000, 32'd3, 10, 0);
        do_div(32'd9, 32'd3, 1'b0);
        abort_div(32'd1000, 32'd0, 1, 1);
        abort_div(32'hDEADBEEF, 32'd17, 20, 2);
        do_div(32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = (i % 8 == 2) ? 32'd0 : -$urandom_range(1, 300);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_div(a, b, 1'(i % 2));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_res.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
